// File: rtl/ipg_ingress_parser.sv
// IPG ingress parser: classifies received 64-bit IPG blocks as rreq, rresp or
// wreq, keeps one message context per type so the three types may interleave
// block by block, tags each forwarded block with its message's src/dst and
// flags out-of-sequence and over-length messages. One cycle of latency; all
// outputs are registered.
module ipg_ingress_parser #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADR_WIDTH      = 40,
  parameter int MAX_MSG_BLOCKS = 16,
  parameter int LEN_WIDTH      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_ipg_en,
  input  logic [DATA_WIDTH-1:0]  rx_ipg_data,
  output logic [ADR_WIDTH/2-1:0] src,
  output logic [ADR_WIDTH/2-1:0] dst,
  output logic                   rreq_valid,
  output logic                   rresp_valid,
  output logic                   wreq_valid,
  output logic [DATA_WIDTH-1:0]  fwd_ipg_data,
  output logic                   fwd_last,
  output logic [LEN_WIDTH-1:0]   msg_len,
  output logic                   err_unexp,
  output logic                   err_len
);

  localparam int HALF = ADR_WIDTH / 2;
  localparam int NCTX = 3;

  // Block type codes in bits [3:0].
  localparam logic [3:0] TYPE_RREQ  = 4'ha;
  localparam logic [3:0] TYPE_RRESP = 4'hb;
  localparam logic [3:0] TYPE_WREQ  = 4'hc;

  // Block control codes in bits [7:4].
  localparam logic [3:0] CTRL_LAST   = 4'h0;
  localparam logic [3:0] CTRL_START  = 4'h1;
  localparam logic [3:0] CTRL_CONT   = 4'h2;
  localparam logic [3:0] CTRL_SINGLE = 4'h3;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_MSG_BLOCKS);
  localparam logic [LEN_WIDTH-1:0] ONE_LEN = LEN_WIDTH'(1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ctx_state_e;

  // Per-type message contexts: 0 = rreq, 1 = rresp, 2 = wreq.
  ctx_state_e           ctx_state_q [NCTX];
  ctx_state_e           ctx_state_d [NCTX];
  logic [HALF-1:0]      ctx_src_q   [NCTX];
  logic [HALF-1:0]      ctx_src_d   [NCTX];
  logic [HALF-1:0]      ctx_dst_q   [NCTX];
  logic [HALF-1:0]      ctx_dst_d   [NCTX];
  logic [LEN_WIDTH-1:0] ctx_cnt_q   [NCTX];
  logic [LEN_WIDTH-1:0] ctx_cnt_d   [NCTX];

  // Registered outputs.
  logic [NCTX-1:0]       valid_q, valid_d;
  logic [HALF-1:0]       src_q, src_d;
  logic [HALF-1:0]       dst_q, dst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  err_unexp_q, err_unexp_d;
  logic                  err_len_q, err_len_d;

  // Field decode of the incoming block.
  logic            type_ok;
  logic [1:0]      ctx_idx;
  logic [3:0]      ctrl;
  logic [HALF-1:0] new_src;
  logic [HALF-1:0] new_dst;

  // Decode the type into a context index and pull out ctrl and start addresses.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    type_ok = 1'b1;
    ctx_idx = 2'd0;
    unique case (rx_ipg_data[3:0])
      TYPE_RREQ:  ctx_idx = 2'd0;
      TYPE_RRESP: ctx_idx = 2'd1;
      TYPE_WREQ:  ctx_idx = 2'd2;
      default:    type_ok = 1'b0;
    endcase
    ctrl    = rx_ipg_data[7:4];
    new_dst = rx_ipg_data[8 +: HALF];
    new_src = rx_ipg_data[8 + HALF +: HALF];
  end

  // Next-state logic: update at most the one context addressed by this block
  // and compute the outputs for the following cycle.
  always_comb begin
    logic fwd;
    fwd         = 1'b0;
    ctx_state_d = ctx_state_q;
    ctx_src_d   = ctx_src_q;
    ctx_dst_d   = ctx_dst_q;
    ctx_cnt_d   = ctx_cnt_q;
    valid_d     = '0;
    last_d      = 1'b0;
    err_unexp_d = 1'b0;
    err_len_d   = 1'b0;
    // Address, data and length outputs hold unless a block is forwarded.
    src_d       = src_q;
    dst_d       = dst_q;
    data_d      = data_q;
    len_d       = len_q;

    if (rx_ipg_en) begin
      if (!type_ok) begin
        err_unexp_d = 1'b1;
      end else begin
        unique case (ctrl)
          CTRL_START, CTRL_SINGLE: begin
            // A start always opens a fresh message; one arriving mid-message
            // abandons the old one and is reported.
            err_unexp_d          = (ctx_state_q[ctx_idx] == ST_ACTIVE);
            ctx_src_d[ctx_idx]   = new_src;
            ctx_dst_d[ctx_idx]   = new_dst;
            ctx_cnt_d[ctx_idx]   = ONE_LEN;
            ctx_state_d[ctx_idx] = (ctrl == CTRL_START) ? ST_ACTIVE : ST_IDLE;
            fwd                  = 1'b1;
            src_d                = new_src;
            dst_d                = new_dst;
            len_d                = ONE_LEN;
            last_d               = (ctrl == CTRL_SINGLE);
          end
          CTRL_CONT, CTRL_LAST: begin
            if (ctx_state_q[ctx_idx] == ST_IDLE) begin
              err_unexp_d = 1'b1;
            end else if (ctx_cnt_q[ctx_idx] >= MAX_LEN) begin
              // Over-length: drop the block and close the message so its
              // remaining blocks are reported as out of sequence.
              err_len_d            = 1'b1;
              ctx_state_d[ctx_idx] = ST_IDLE;
            end else begin
              ctx_cnt_d[ctx_idx] = ctx_cnt_q[ctx_idx] + ONE_LEN;
              if (ctrl == CTRL_LAST) begin
                ctx_state_d[ctx_idx] = ST_IDLE;
              end
              fwd    = 1'b1;
              src_d  = ctx_src_q[ctx_idx];
              dst_d  = ctx_dst_q[ctx_idx];
              len_d  = ctx_cnt_q[ctx_idx] + ONE_LEN;
              last_d = (ctrl == CTRL_LAST);
            end
          end
          default: err_unexp_d = 1'b1;
        endcase
      end
    end

    if (fwd) begin
      valid_d[ctx_idx] = 1'b1;
      data_d           = rx_ipg_data;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    if (rst) begin
      // NOTE: the contexts are reset like ordinary flops because an in-flight
      // message must be discarded; they are only three entries, not a RAM.
      for (int i = 0; i < NCTX; i++) begin
        ctx_state_q[i] <= ST_IDLE;
        ctx_src_q[i]   <= '0;
        ctx_dst_q[i]   <= '0;
        ctx_cnt_q[i]   <= '0;
      end
      valid_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      len_q       <= '0;
      err_unexp_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      ctx_state_q <= ctx_state_d;
      ctx_src_q   <= ctx_src_d;
      ctx_dst_q   <= ctx_dst_d;
      ctx_cnt_q   <= ctx_cnt_d;
      valid_q     <= valid_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      last_q      <= last_d;
      len_q       <= len_d;
      err_unexp_q <= err_unexp_d;
      err_len_q   <= err_len_d;
    end
  end

  assign rreq_valid   = valid_q[0];
  assign rresp_valid  = valid_q[1];
  assign wreq_valid   = valid_q[2];
  assign src          = src_q;
  assign dst          = dst_q;
  assign fwd_ipg_data = data_q;
  assign fwd_last     = last_q;
  assign msg_len      = len_q;
  assign err_unexp    = err_unexp_q;
  assign err_len      = err_len_q;

endmodule
